spi_xfer_queue: RTL
===================

// Module: spi_xfer_queue
// PURPOSE
//   Byte-stream queue between the APB register block and the SPI master core.
//   TX FIFO is filled by the bus; an FSM pops one byte at a time, pulses 'go' to the core,
//   waits for 'done', and pushes the received byte into the RX FIFO for the bus to read.
//   Lets firmware queue up to DEPTH bytes per burst instead of polling DONE per byte.
// PARAMETERS
//   DW     8   data width of each transfer (matches core DATA_WIDTH)
//   DEPTH  16  entries per FIFO; power of two, >= 2
//   AW     4   log2(DEPTH); level outputs are AW+1 bits
// PORTS
//   PCLK       in   1     clock
//   PRESETn    in   1     async active-low reset
//   enable     in   1     1 = FSM may start new transfers
//   flush      in   1     1-cycle pulse: empty both FIFOs
//   tx_wr      in   1     push tx_wdata into TX FIFO
//   tx_wdata   in   DW    byte to transmit
//   tx_full    out  1     TX FIFO holds DEPTH entries
//   tx_level   out  AW+1  TX entry count
//   rx_rd      in   1     pop RX FIFO head
//   rx_rdata   out  DW    RX FIFO head (first-word fall-through)
//   rx_empty   out  1     RX FIFO holds 0 entries
//   rx_level   out  AW+1  RX entry count
//   tx_ovf     out  1     sticky: write attempted while TX full
//   rx_ovf     out  1     sticky: received byte dropped, RX full
//   ovf_clr    in   1     clears tx_ovf and rx_ovf
//   idle       out  1     FSM in IDLE and TX FIFO empty
//   go         out  1     to core: registered 1-cycle start pulse
//   datai      out  DW    to core: byte being sent, held stable from go until done
//   busy       in   1     from core: transfer in progress (status only)
//   done       in   1     from core: 1-cycle completion pulse
//   datao      in   DW    from core: received byte, valid with done
// BEHAVIOUR
//   Reset values: go=0, datai=0, tx_full=0, tx_level=0, rx_empty=1, rx_level=0,
//     rx_rdata=0, tx_ovf=0, rx_ovf=0, idle=1, state=IDLE. Reset mid-transfer aborts all state.
//   FIFOs: circular buffers, AW-bit pointers wrap DEPTH-1 -> 0; level is AW+1 bits, 0..DEPTH.
//     tx_wr while full: dropped, tx_ovf<=1. rx_rd while empty: ignored, no state change.
//     Push and pop in the same cycle: both occur, level unchanged. On a full RX FIFO this
//     is not an overflow.
//   FSM states: IDLE -> START -> WAIT -> IDLE.
//     IDLE:  if enable & tx_level!=0 & ~flush: pop TX, datai<=head, go<=1, goto START.
//     START: go<=0, goto WAIT. Exactly one go cycle per byte.
//     WAIT:  on done: push datao to RX (if RX full and no same-cycle rx_rd: drop,
//            rx_ovf<=1), goto IDLE. Any done seen in IDLE or START is ignored.
//   Latency: write at edge N into empty TX with enable=1 and IDLE -> go high from edge N+1.
//     Back-to-back: the next go comes 1 cycle after done (one IDLE cycle between bytes).
//   enable=0 mid-transfer: the current byte completes and is stored. No new START follows.
//   flush: both FIFOs empty at the next edge and tx_wr/rx_rd that cycle are ignored.
//     An in-flight transfer (START/WAIT) still completes. Its received byte is discarded,
//     with no RX push and no rx_ovf. The FSM then returns to IDLE.
//   ovf_clr and a new overflow in the same cycle: the overflow wins, so the flag stays 1.
//   datai holds its last value in IDLE. busy is never used for control.
// TESTING
//   1. Reset asserted mid-WAIT -> all outputs at reset values, and go stays 0 after release.
//   2. enable=1; write A5,3C; core model returns ~datai 4 cycles after go -> two go pulses
//      with datai=A5 then 3C; rx_rdata=5A then C3; rx_level 2->0; idle=1 at end.
//   3. enable=0; 17 writes 00..10 -> tx_full=1, tx_level=16, tx_ovf=1; enable=1 -> 16
//      transfers, 00..0F only; ovf_clr -> tx_ovf=0.
//   4. 17 transfers, no reads -> rx_level=16, rx_ovf=1, first rx_rdata=first byte, 17th lost.
//      Repeat with rx_rd on the 17th done -> rx_ovf=0, rx_level stays 16.
//   5. 3 bytes queued; flush during WAIT -> tx_level=0, rx_level=0 next cycle; done of the
//      in-flight byte produces no RX push; no further go.
//   6. Drop enable during WAIT with 2 bytes left -> current byte lands in RX, tx_level=2,
//      no go until enable=1 again.

Source files
------------

// File: rtl/spi_xfer_queue_if.sv
// Bus- and core-facing signal bundle for spi_xfer_queue.
// The master modport is the side that drives the queue: register block plus SPI core.
interface spi_xfer_queue_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    // Handshakes:
    //  - tx_wr pushes tx_wdata when tx_full is low; a write while full is dropped and flagged.
    //  - rx_rd pops the head shown on rx_rdata when rx_empty is low; otherwise it is ignored.
    //  - go is a single-cycle request, datai is stable until done, and done carries datao.
    logic          enable;
    logic          flush;
    logic          tx_wr;
    logic [DW-1:0] tx_wdata;
    logic          tx_full;
    logic [AW:0]   tx_level;
    logic          rx_rd;
    logic [DW-1:0] rx_rdata;
    logic          rx_empty;
    logic [AW:0]   rx_level;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          ovf_clr;
    logic          idle;
    logic          go;
    logic [DW-1:0] datai;
    logic          busy;
    logic          done;
    logic [DW-1:0] datao;
    logic [1:0]    state_dbg;

    modport master (
        output enable, flush, tx_wr, tx_wdata, rx_rd, ovf_clr, busy, done, datao,
        input  tx_full, tx_level, rx_rdata, rx_empty, rx_level, tx_ovf, rx_ovf,
               idle, go, datai, state_dbg
    );

    modport slave (
        input  enable, flush, tx_wr, tx_wdata, rx_rd, ovf_clr, busy, done, datao,
        output tx_full, tx_level, rx_rdata, rx_empty, rx_level, tx_ovf, rx_ovf,
               idle, go, datai, state_dbg
    );
endinterface

// File: rtl/spi_xfer_queue.sv
// TX/RX byte FIFOs around the SPI master core; an FSM feeds one TX byte per transfer
// and stores each received byte in the RX FIFO.
module spi_xfer_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    spi_xfer_queue_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_tx_mem [DEPTH];
    logic [DW-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [AW:0]   r_tx_level;
    logic [AW:0]   r_rx_level;
    logic          r_tx_ovf;
    logic          r_rx_ovf;
    logic          r_go;
    logic [DW-1:0] r_datai;
    logic          r_discard;

    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_done_wait;
    logic          w_tx_ovf_set;
    logic          w_rx_ovf_set;
    logic          w_keep_byte;

    assign w_tx_full  = (r_tx_level == LVL_FULL);
    assign w_tx_empty = (r_tx_level == '0);
    assign w_rx_full  = (r_rx_level == LVL_FULL);
    assign w_rx_empty = (r_rx_level == '0);

    // Flush overrides every bus access in its cycle.
    assign w_tx_push    = bus.tx_wr & ~w_tx_full & ~bus.flush;
    assign w_tx_ovf_set = bus.tx_wr &  w_tx_full & ~bus.flush;
    assign w_rx_pop     = bus.rx_rd & ~w_rx_empty & ~bus.flush;

    // A byte whose transfer was in flight during a flush is thrown away silently.
    assign w_keep_byte  = w_done_wait & ~r_discard & ~bus.flush;
    assign w_rx_push    = w_keep_byte & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf_set = w_keep_byte &   w_rx_full & ~w_rx_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        w_done_wait = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enable && !w_tx_empty && !bus.flush) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.done) begin
                    w_done_wait = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_go      <= 1'b0;
            r_datai   <= '0;
            r_discard <= 1'b0;
        end else begin
            r_go <= w_tx_pop;
            if (w_tx_pop) begin
                r_datai <= r_tx_mem[r_tx_rptr];
            end
            if (w_done_wait) begin
                r_discard <= 1'b0;
            end else if (bus.flush && (r_state != S_IDLE)) begin
                r_discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= bus.tx_wdata;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= bus.datao;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else if (bus.flush) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            r_tx_level <= r_tx_level + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else if (bus.flush) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            r_rx_level <= r_rx_level + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};
        end
    end

    // A fresh overflow in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_tx_ovf_set) begin
                r_tx_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_rx_ovf_set) begin
                r_rx_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_rx_ovf <= 1'b0;
            end
        end
    end

    assign bus.tx_full   = w_tx_full;
    assign bus.tx_level  = r_tx_level;
    assign bus.rx_empty  = w_rx_empty;
    assign bus.rx_level  = r_rx_level;
    assign bus.rx_rdata  = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
    assign bus.tx_ovf    = r_tx_ovf;
    assign bus.rx_ovf    = r_rx_ovf;
    assign bus.idle      = (r_state == S_IDLE) && w_tx_empty;
    assign bus.go        = r_go;
    assign bus.datai     = r_datai;
    assign bus.state_dbg = r_state;
endmodule
